// File: rtl/reduction_pkg.sv
// Shared constants and FSM state type for the projective-to-affine normaliser.
// Montgomery radix is R = 2^255, so R mod P = 19 and R^2 mod P = 361.
package reduction_pkg;

  localparam logic [254:0] P_25519 =
    255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

  localparam int           R2     = 361;
  localparam logic [254:0] R2_255 = 255'd361;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INV,
    S_MUL,
    S_NORM,
    S_DONE
  } state_t;

endpackage

// File: rtl/Montgomery.sv
// Bit-serial Montgomery multiplier: o_result = a*b*2^-WIDTH mod P.
// o_finished pulses WIDTH+1 cycles after the i_start cycle.
module Montgomery
  import reduction_pkg::*;
#(
  parameter int               WIDTH = 255,
  parameter logic [WIDTH-1:0] P     = P_25519
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished
);
  localparam int               CW    = $clog2(WIDTH);
  localparam logic [WIDTH+1:0] P_EXT = {2'b00, P};

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH+1:0] acc, sum, sum_odd, step;

  // acc stays below 2P, so two guard bits hold acc + b + P
  always_comb begin
    sum     = acc + (a_q[0] ? {2'b00, b_q} : '0);
    sum_odd = sum[0] ? sum + P_EXT : sum;
    step    = sum_odd >> 1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy       <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      o_result   <= '0;
      o_finished <= 1'b0;
    end else begin
      o_finished <= 1'b0;
      if (i_start && !busy) begin
        busy <= 1'b1;
        cnt  <= '0;
        acc  <= '0;
        a_q  <= i_a;
        b_q  <= i_b;
      end else if (busy) begin
        acc <= step;
        a_q <= a_q >> 1;
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy       <= 1'b0;
          o_finished <= 1'b1;
          o_result   <= (step >= P_EXT) ? WIDTH'(step - P_EXT) : step[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/MontgomeryInv.sv
// Montgomery inverse: o_result = a^-1 * 2^WIDTH mod P (a != 0), fixed latency:
// o_finished pulses 3*WIDTH+2 cycles after the i_start cycle.
module MontgomeryInv
  import reduction_pkg::*;
#(
  parameter int               WIDTH = 255,
  parameter logic [WIDTH-1:0] P     = P_25519
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finished
);
  localparam int               PH1   = 2 * WIDTH;
  localparam int               LAST  = 3 * WIDTH;
  localparam int               KW    = $clog2(LAST + 1);
  localparam logic [WIDTH+1:0] P_EXT = {2'b00, P};

  logic             busy;
  logic [KW-1:0]    cnt, k, k1_n, k2_n;
  logic [WIDTH-1:0] u, v, u_n, v_n;
  logic [WIDTH+1:0] r, s, r_n, s_n, r_red, r_dbl, r2_n;

  // Almost-inverse step: leaves r with p - r = a^-1 * 2^k once v reaches zero
  always_comb begin
    u_n  = u;
    v_n  = v;
    r_n  = r;
    s_n  = s;
    k1_n = k;
    if (v != '0) begin
      k1_n = k + KW'(1);
      if (!u[0]) begin
        u_n = u >> 1;
        s_n = s << 1;
      end else if (!v[0]) begin
        v_n = v >> 1;
        r_n = r << 1;
      end else if (u > v) begin
        u_n = (u - v) >> 1;
        r_n = r + s;
        s_n = s << 1;
      end else begin
        v_n = (v - u) >> 1;
        s_n = s + r;
        r_n = r << 1;
      end
    end
  end

  // Exponent correction: move 2^k towards 2^WIDTH by modular halving or doubling
  always_comb begin
    r_red = (r >= P_EXT) ? r - P_EXT : r;
    r_dbl = r << 1;
    r2_n  = r;
    k2_n  = k;
    if (k > KW'(WIDTH)) begin
      r2_n = r[0] ? (r + P_EXT) >> 1 : r >> 1;
      k2_n = k - KW'(1);
    end else if (k < KW'(WIDTH)) begin
      r2_n = (r_dbl >= P_EXT) ? r_dbl - P_EXT : r_dbl;
      k2_n = k + KW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy       <= 1'b0;
      cnt        <= '0;
      k          <= '0;
      u          <= '0;
      v          <= '0;
      r          <= '0;
      s          <= '0;
      o_result   <= '0;
      o_finished <= 1'b0;
    end else begin
      o_finished <= 1'b0;
      if (i_start && !busy) begin
        busy <= 1'b1;
        cnt  <= '0;
        k    <= '0;
        u    <= P;
        v    <= i_a;
        r    <= '0;
        s    <= (WIDTH + 2)'(1);
      end else if (busy) begin
        cnt <= cnt + KW'(1);
        if (cnt < KW'(PH1)) begin
          u <= u_n;
          v <= v_n;
          r <= r_n;
          s <= s_n;
          k <= k1_n;
        end else if (cnt == KW'(PH1)) begin
          r <= P_EXT - r_red;
        end else begin
          r <= r2_n;
          k <= k2_n;
          if (cnt == KW'(LAST)) begin
            busy       <= 1'b0;
            o_finished <= 1'b1;
            o_result   <= r2_n[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule

// File: rtl/reduction_multi_even_norm.sv
// Even-sign normalisation of one field element: odd values map to P - v.
module even_norm
  import reduction_pkg::*;
#(
  parameter int               WIDTH = 255,
  parameter logic [WIDTH-1:0] P     = P_25519
) (
  input  logic [WIDTH-1:0] value,
  input  logic             enable,
  output logic [WIDTH-1:0] result
);

  assign result = (enable && value[0]) ? P - value : value;

endmodule

// File: rtl/reduction_multi.sv
// Projective-to-affine normaliser: a_k = c_k * z^-1 mod P for every coordinate,
// one shared inversion, one multiplier used serially, optional even-sign fix-up.
module reduction_multi
  import reduction_pkg::*;
#(
  parameter int                   WIDTH     = 255,
  parameter int                   NUM_COORD = 2,
  parameter logic [WIDTH-1:0]     P         = P_25519,
  parameter bit                   NORM_EVEN = 1'b1,
  parameter logic [NUM_COORD-1:0] NORM_MASK = '1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  output logic                       o_ready,
  input  logic [NUM_COORD*WIDTH-1:0] i_coords,
  input  logic [WIDTH-1:0]           i_z,
  output logic [NUM_COORD*WIDTH-1:0] o_coords,
  output logic                       o_valid,
  output logic                       o_err
);
  localparam int IW = (NUM_COORD > 1) ? $clog2(NUM_COORD) : 1;

  state_t           state, next_state;
  logic [WIDTH-1:0] coords_q [NUM_COORD];
  logic [WIDTH-1:0] normed   [NUM_COORD];
  logic [WIDTH-1:0] inv_q, inv_result, mul_result, mul_a, mul_b;
  logic [IW-1:0]    idx, mul_sel;
  logic             inv_start, inv_done, mul_start, mul_done, err_q, last_coord;

  assign last_coord = (idx == IW'(NUM_COORD - 1));
  assign mul_a      = coords_q[mul_sel];
  assign mul_b      = (state == S_INV) ? inv_result : inv_q;

  always_comb begin
    next_state = state;
    inv_start  = 1'b0;
    mul_start  = 1'b0;
    mul_sel    = '0;
    unique case (state)
      S_IDLE:
        if (i_start) begin
          if (i_z == '0) begin
            next_state = S_DONE;
          end else begin
            inv_start  = 1'b1;
            next_state = S_INV;
          end
        end
      S_INV:
        if (inv_done) begin
          mul_start  = 1'b1;
          next_state = S_MUL;
        end
      S_MUL:
        if (mul_done) begin
          if (last_coord) begin
            next_state = S_NORM;
          end else begin
            mul_start = 1'b1;
            mul_sel   = idx + IW'(1);
          end
        end
      S_NORM:  next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // The coordinate registers double as the held output value
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      idx   <= '0;
      err_q <= 1'b0;
      inv_q <= '0;
      for (int k = 0; k < NUM_COORD; k++) coords_q[k] <= '0;
    end else begin
      state <= next_state;
      unique case (state)
        S_IDLE:
          if (i_start) begin
            err_q <= (i_z == '0);
            for (int k = 0; k < NUM_COORD; k++)
              coords_q[k] <= (i_z == '0) ? '0 : i_coords[k*WIDTH +: WIDTH];
          end
        S_INV:
          if (inv_done) begin
            inv_q <= inv_result;
            idx   <= '0;
          end
        S_MUL:
          if (mul_done) begin
            coords_q[idx] <= mul_result;
            if (!last_coord) idx <= idx + IW'(1);
          end
        S_NORM:
          for (int k = 0; k < NUM_COORD; k++) coords_q[k] <= normed[k];
        default: ;
      endcase
    end
  end

  assign o_ready = (state == S_IDLE);
  assign o_valid = (state == S_DONE);
  assign o_err   = err_q;

  for (genvar k = 0; k < NUM_COORD; k++) begin : g_coord
    even_norm #(.WIDTH(WIDTH), .P(P)) u_norm (
      .value  (coords_q[k]),
      .enable (NORM_EVEN && NORM_MASK[k]),
      .result (normed[k])
    );
    assign o_coords[k*WIDTH +: WIDTH] = coords_q[k];
  end

  MontgomeryInv #(.WIDTH(WIDTH), .P(P)) u_inv (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (inv_start),
    .i_a        (i_z),
    .o_result   (inv_result),
    .o_finished (inv_done)
  );

  Montgomery #(.WIDTH(WIDTH), .P(P)) u_mul (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (mul_start),
    .i_a        (mul_a),
    .i_b        (mul_b),
    .o_result   (mul_result),
    .o_finished (mul_done)
  );

endmodule

// File: tb/tb_reduction_multi.sv
// Scoreboard bench for reduction_multi: three configurations side by side,
// directed vectors with hand-computed affine results and latencies.
module tb_reduction_multi;

  localparam int           W = 255;
  localparam logic [W-1:0] P = W'((256'd1 << 255) - 256'd19);
  // Fixed sub-unit latencies, start cycle to finished-pulse cycle
  localparam int T_INV = 3 * W + 2;
  localparam int T_MUL = W + 1;
  // Cycles counted from the start cycle through the o_valid cycle inclusive
  localparam int LAT_2 = 1 + T_INV + 2 * T_MUL + 1 + 1;
  localparam int LAT_3 = 1 + T_INV + 3 * T_MUL + 1 + 1;
  localparam int BUDGET = 4000;

  typedef struct {
    logic [W-1:0] c [3];
    logic         err;
    int           lat;
    int           t0;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     start;
  logic [3*W-1:0] coords_in;
  logic [W-1:0]   z_in;
  logic [2:0]     ready, valid, err;
  logic [2*W-1:0] out_a, out_b;
  logic [3*W-1:0] out_c;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_miss = 0;
  exp_t q_a[$], q_b[$], q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reduction_multi u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .o_ready(ready[0]),
    .i_coords(coords_in[2*W-1:0]), .i_z(z_in),
    .o_coords(out_a), .o_valid(valid[0]), .o_err(err[0])
  );

  reduction_multi #(.NORM_EVEN(1'b0)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .o_ready(ready[1]),
    .i_coords(coords_in[2*W-1:0]), .i_z(z_in),
    .o_coords(out_b), .o_valid(valid[1]), .o_err(err[1])
  );

  reduction_multi #(.NUM_COORD(3), .NORM_MASK(3'b011)) u_c (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]), .o_ready(ready[2]),
    .i_coords(coords_in), .i_z(z_in),
    .o_coords(out_c), .o_valid(valid[2]), .o_err(err[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectEq(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_checks++;
    if (act !== want) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, want);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int d);
    case (d)
      0:       return q_a.pop_front();
      1:       return q_b.pop_front();
      default: return q_c.pop_front();
    endcase
  endfunction

  task automatic waitReady(input int d);
    int n = 0;
    while (!ready[d] && n < BUDGET) begin
      tick();
      n++;
    end
    if (!ready[d]) begin
      n_checks++;
      n_miss++;
      $display("[TB] FAIL ready_timeout dut%0d: o_ready still 0 after %0d cycles, required 1", d, BUDGET);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < BUDGET) begin
      tick();
      n++;
    end
    if ((q_a.size() + q_b.size() + q_c.size()) != 0) begin
      n_checks++;
      n_miss++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0",
               q_a.size() + q_b.size() + q_c.size());
      q_a.delete();
      q_b.delete();
      q_c.delete();
    end
  endtask

  task automatic drive(input int d, input logic [W-1:0] c0, c1, c2, z);
    coords_in = {c2, c1, c0};
    z_in      = z;
    start     = '0;
    start[d]  = 1'b1;
    tick();
    start     = '0;
  endtask

  task automatic applyStimulus(input int d, input logic [W-1:0] c0, c1, c2, z,
                               input logic [W-1:0] e0, e1, e2, input logic e_err, input int lat);
    exp_t e;
    waitReady(d);
    e.c[0] = e0;
    e.c[1] = e1;
    e.c[2] = e2;
    e.err  = e_err;
    e.lat  = lat;
    e.t0   = cyc;
    case (d)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
    drive(d, c0, c1, c2, z);
  endtask

  task automatic checkOutput(input int d);
    exp_t         e;
    logic [W-1:0] act [3];
    int           nc;
    if (qsize(d) == 0) begin
      n_checks++;
      n_miss++;
      $display("[TB] FAIL unexpected_valid dut%0d: got o_valid=1, required no pulse", d);
      return;
    end
    e      = qpop(d);
    act[0] = '0;
    act[1] = '0;
    act[2] = '0;
    case (d)
      0: begin act[0] = out_a[0 +: W]; act[1] = out_a[W +: W]; end
      1: begin act[0] = out_b[0 +: W]; act[1] = out_b[W +: W]; end
      default: begin
        act[0] = out_c[0 +: W];
        act[1] = out_c[W +: W];
        act[2] = out_c[2*W +: W];
      end
    endcase
    nc = (d == 2) ? 3 : 2;
    for (int i = 0; i < nc; i++)
      expectEq($sformatf("dut%0d_coord%0d", d, i), act[i], e.c[i]);
    expectEq($sformatf("dut%0d_err", d), W'(err[d]), W'(e.err));
    expectEq($sformatf("dut%0d_latency", d), W'(cyc - e.t0 + 1), W'(e.lat));
    expectEq($sformatf("dut%0d_ready_during_valid", d), W'(ready[d]), '0);
  endtask

  // Monitor: independent of stimulus, checks every o_valid pulse
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++)
      if (valid[d]) checkOutput(d);
  end

  initial begin
    rst       = 1'b1;
    start     = '0;
    coords_in = '0;
    z_in      = '0;
    repeat (3) tick();
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      expectEq($sformatf("reset_ready%0d", d), W'(ready[d]), W'(1));
      expectEq($sformatf("reset_valid%0d", d), W'(valid[d]), '0);
      expectEq($sformatf("reset_err%0d", d), W'(err[d]), '0);
    end
    expectEq("reset_coords_a", out_a[0 +: W] | out_a[W +: W], '0);
    expectEq("reset_coords_c", out_c[0 +: W] | out_c[W +: W] | out_c[2*W +: W], '0);

    // Three configurations run concurrently
    applyStimulus(0, 6, 10, 0, 2, P - 3, P - 5, 0, 1'b0, LAT_2);
    applyStimulus(1, 6, 10, 0, 2, 3, 5, 0, 1'b0, LAT_2);
    applyStimulus(2, P - 1, 6, 2, 1, P - 1, 6, 2, 1'b0, LAT_3);
    applyStimulus(0, 8, 4, 0, 2, 4, 2, 0, 1'b0, LAT_2);
    applyStimulus(1, P - 1, 1, 0, P - 1, 1, P - 1, 0, 1'b0, LAT_2);
    applyStimulus(2, 0, 9, 15, 3, 0, P - 3, 5, 1'b0, LAT_3);
    applyStimulus(0, P - 1, 1, 0, P - 1, P - 1, P - 1, 0, 1'b0, LAT_2);
    applyStimulus(0, 7, 9, 0, 0, 0, 0, 0, 1'b1, 2);

    // Second start during the multiply phase must be ignored
    applyStimulus(0, 6, 10, 0, 2, P - 3, P - 5, 0, 1'b0, LAT_2);
    repeat (T_INV + 50) tick();
    expectEq("busy_ready", W'(ready[0]), '0);
    drive(0, 8, 4, 0, 2);
    waitDrain();

    // Reset during the multiply phase aborts the job with no o_valid
    waitReady(0);
    drive(0, 6, 10, 0, 2);
    repeat (T_INV + 100) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expectEq("abort_ready", W'(ready[0]), W'(1));
    expectEq("abort_valid", W'(valid[0]), '0);
    expectEq("abort_coords", out_a[0 +: W] | out_a[W +: W], '0);
    repeat (1500) tick();

    applyStimulus(0, 6, 10, 0, 2, P - 3, P - 5, 0, 1'b0, LAT_2);
    waitDrain();
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
